dlfloat16_round_arb: RTL and testbench
======================================

DLFLOAT16_ROUND_ARB -- requirements
Module: dlfloat16_round_arb

Interface
REQ-001 Parameter NREQ, default 3, number of requesters sharing the single rounding unit; legal range 2..8.
REQ-002 Parameter CNTW, default 16, width of the completed-operation counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NREQ  per-requester operation pending.
REQ-006 req_ready  output  NREQ  one-hot grant; a request is accepted on the edge where req_valid[i] && req_ready[i].
REQ-007 req_data  input  NREQ*20  packed unrounded operands; slice i is {sign, exp[5:0], mant[8:0], G, R, S1, S2}.
REQ-008 req_rm  input  NREQ*3  packed rounding modes: 000 RNE, 001 RTZ, 010 RUP, 011 RDN.
REQ-009 rnd_in  output  20  operand driven to the rounding unit.
REQ-010 rnd_rm  output  3  rounding mode driven to the rounding unit.
REQ-011 rnd_out  input  32  registered rounding-unit result; only bits [15:0] are used.
REQ-012 rsp_valid  output  1  result available; rsp_ready  input  1  consumer accepts.
REQ-013 rsp_data  output  16  rounded DLFloat16 result; rsp_id  output  3  index of the originating requester.
REQ-014 rsp_inv_rm  output  1  requested mode was illegal and was replaced by 000.
REQ-015 busy  output  1  state is not IDLE; op_cnt  output  CNTW  completed responses.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
REQ-017 IDLE: req_ready is the one-hot winner among req_valid (all zero if none valid); on the accept edge, latch the winner's data, rm and id into op registers, then go to ISSUE.
REQ-018 Arbitration: round-robin; search starts at last_grant+1 modulo NREQ; last_grant updates on each accept.
REQ-019 req_ready is 0 in ISSUE, WAIT and RESP.
REQ-020 rnd_in/rnd_rm are driven from the op registers at all times and hold their value until the next accept.
REQ-021 If the latched rm > 3'b011, rnd_rm is 3'b000 and the op's inv flag is set; otherwise rnd_rm equals the latched rm.
REQ-022 ISSUE lasts one cycle (the rounding unit registers on the edge leaving ISSUE), then WAIT.
REQ-023 WAIT lasts one cycle; on the edge leaving WAIT, capture rnd_out[15:0] into rsp_data, then go to RESP.
REQ-024 RESP: rsp_valid=1; rsp_data, rsp_id and rsp_inv_rm are stable until rsp_ready; on rsp_valid && rsp_ready, increment op_cnt and go to IDLE.
REQ-025 Latency: accept at edge T gives rsp_valid high from edge T+3; minimum issue interval is 4 cycles.
REQ-026 op_cnt wraps from all-ones to 0 without a flag.
REQ-027 rsp_ready while rsp_valid=0 is ignored; req_valid deasserting while not granted is legal and is not recorded.

Reset
REQ-028 While rst_n=0: state IDLE, req_ready=0, rnd_in=0, rnd_rm=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_inv_rm=0, op_cnt=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-029 Reset mid-operation discards the in-flight op with no response; the first grant after release follows REQ-028.

Configuration
REQ-030 Macro DLF_RND_ARB_FIXED_PRIO_EN: when defined, the lowest valid index always wins and last_grant is not implemented; when undefined, round-robin per REQ-018 applies.

Verification
REQ-031 Req0 valid, data 20'h1E018, rm 000, stub rnd_out=16'h1E02 one cycle after ISSUE -> rsp_valid at T+3, rsp_data 16'h1E02, rsp_id 0, rsp_inv_rm 0, op_cnt 1.
REQ-032 All three requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,0,1,2; with FIXED_PRIO_EN -> 0,0,0,...
REQ-033 Req1 rm 3'b101 -> rnd_rm 000 during ISSUE/WAIT, rsp_inv_rm 1, rsp_id 1.
REQ-034 rsp_ready held low for 5 cycles in RESP -> rsp_data/rsp_id stable, req_ready all 0, no new accept until the handshake.
REQ-035 rst_n pulsed low in WAIT -> rsp_valid 0 immediately, no response emitted, next grant goes to req0.
REQ-036 Preload op_cnt to all-ones via 2^CNTW-1 completions (or force) and complete one more -> op_cnt 0.

Source files
------------

// File: rtl/dlfloat16_round_arb.sv
// Arbitrates NREQ requesters onto one registered DLFloat16 rounding unit, one op in flight.
// Optional build macro DLF_RND_ARB_FIXED_PRIO_EN: lowest valid index always wins (no round-robin state).
module dlfloat16_round_arb #(
    parameter int NREQ = 3,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*20-1:0] req_data,
    input  logic [NREQ*3-1:0] req_rm,
    output logic [19:0]       rnd_in,
    output logic [2:0]        rnd_rm,
    input  logic [31:0]       rnd_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_data,
    output logic [2:0]        rsp_id,
    output logic              rsp_inv_rm,
    output logic              busy,
    output logic [CNTW-1:0]   op_cnt
);

    // state | meaning
    // IDLE  | arbitrating, req_ready carries the one-hot winner
    // ISSUE | op registers drive the rounding unit, which registers on exit
    // WAIT  | rounding result appears on rnd_out, captured on exit
    // RESP  | response held until rsp_ready
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e          state_q;
    logic [19:0]     op_data_q;
    logic [2:0]      op_rm_q;
    logic            op_inv_q;
    logic [2:0]      op_id_q;
    logic [15:0]     rsp_data_q;
    logic [CNTW-1:0] op_cnt_q;

    logic [NREQ-1:0] grant;
    logic            win_found;
    logic [2:0]      win_id;
    logic [19:0]     win_data;
    logic [2:0]      win_rm;

`ifdef DLF_RND_ARB_FIXED_PRIO_EN
    always_comb begin
        grant     = '0;
        win_found = 1'b0;
        win_id    = '0;
        win_data  = '0;
        win_rm    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req_valid[i]) begin
                grant[i]  = 1'b1;
                win_found = 1'b1;
                win_id    = 3'(i);
                win_data  = req_data[i*20 +: 20];
                win_rm    = req_rm[i*3 +: 3];
            end
        end
    end
`else
    logic [2:0] last_grant_q;

    // Two passes: indices above last_grant first, then wrap around to the rest.
    always_comb begin
        grant     = '0;
        win_found = 1'b0;
        win_id    = '0;
        win_data  = '0;
        win_rm    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req_valid[i] && (3'(i) > last_grant_q)) begin
                grant[i]  = 1'b1;
                win_found = 1'b1;
                win_id    = 3'(i);
                win_data  = req_data[i*20 +: 20];
                win_rm    = req_rm[i*3 +: 3];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req_valid[i] && (3'(i) <= last_grant_q)) begin
                grant[i]  = 1'b1;
                win_found = 1'b1;
                win_id    = 3'(i);
                win_data  = req_data[i*20 +: 20];
                win_rm    = req_rm[i*3 +: 3];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_data_q  <= '0;
            op_rm_q    <= '0;
            op_inv_q   <= 1'b0;
            op_id_q    <= '0;
            rsp_data_q <= '0;
            op_cnt_q   <= '0;
`ifndef DLF_RND_ARB_FIXED_PRIO_EN
            last_grant_q <= 3'(NREQ - 1);
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        op_data_q <= win_data;
                        op_inv_q  <= (win_rm > 3'b011);
                        op_rm_q   <= (win_rm > 3'b011) ? 3'b000 : win_rm;
                        op_id_q   <= win_id;
`ifndef DLF_RND_ARB_FIXED_PRIO_EN
                        last_grant_q <= win_id;
`endif
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    rsp_data_q <= rnd_out[15:0];
                    state_q    <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        op_cnt_q <= op_cnt_q + CNTW'(1);
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Grant is combinational from req_valid but must stay quiet while reset is held.
    assign req_ready  = (rst_n && state_q == S_IDLE) ? grant : '0;
    assign rnd_in     = op_data_q;
    assign rnd_rm     = op_rm_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = op_id_q;
    assign rsp_inv_rm = op_inv_q;
    assign busy       = (state_q != S_IDLE);
    assign op_cnt     = op_cnt_q;

    logic unused_rnd_hi;
    assign unused_rnd_hi = ^rnd_out[31:16];

endmodule

// File: tb/tb_dlfloat16_round_arb.sv
// Self-checking bench for dlfloat16_round_arb: directed table, reset/hold corners, random ops up to counter wrap.
// Honors DLF_RND_ARB_FIXED_PRIO_EN when the design is built with it.
module tb_dlfloat16_round_arb;
    localparam int NREQ = 3;
    localparam int CNTW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*20-1:0] req_data;
    logic [NREQ*3-1:0] req_rm;
    logic [19:0]       rnd_in;
    logic [2:0]        rnd_rm;
    logic [31:0]       rnd_out = '0;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_data;
    logic [2:0]        rsp_id;
    logic              rsp_inv_rm;
    logic              busy;
    logic [CNTW-1:0]   op_cnt;

    dlfloat16_round_arb #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_rm(req_rm),
        .rnd_in(rnd_in), .rnd_rm(rnd_rm), .rnd_out(rnd_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_inv_rm(rsp_inv_rm), .busy(busy), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    // Rounding-unit stub: round up when any of G/R/S bits set, then tag with the mode.
    function automatic logic [15:0] stub_round(input logic [19:0] x, input logic [2:0] m);
        return (x[19:4] + {15'b0, |x[3:0]}) ^ {m, 13'b0};
    endfunction

    always @(posedge clk) rnd_out <= {16'hDEAD, stub_round(rnd_in, rnd_rm)};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arbitration pointer and completion count.
    int m_last = NREQ - 1;
    int m_cnt  = 0;

    function automatic int m_winner(input logic [NREQ-1:0] v);
`ifdef DLF_RND_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (v[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    task automatic run_op(input logic [NREQ-1:0] v, input logic [NREQ*20-1:0] d,
                          input logic [NREQ*3-1:0] rm, input int hold,
                          output logic [2:0] got_id, output logic [15:0] got_data,
                          output logic got_inv);
        int w;
        logic [2:0]  rm_raw, rm_eff;
        logic        inv;
        logic [19:0] edata;
        logic [15:0] exp_rsp;
        got_id = '0; got_data = '0; got_inv = 1'b0;
        @(negedge clk);
        req_valid = v; req_data = d; req_rm = rm; rsp_ready = 1'b0;
        #1;
        w = m_winner(v);
        chk("req_ready_idle", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w < 0) begin
            @(posedge clk); #1;
            chk("no_accept_busy", 32'(busy), 32'd0);
            return;
        end
        rm_raw  = rm[w*3 +: 3];
        inv     = (rm_raw > 3'b011);
        rm_eff  = inv ? 3'b000 : rm_raw;
        edata   = d[w*20 +: 20];
        exp_rsp = stub_round(edata, rm_eff);
        @(posedge clk);
        m_last = w;
        #1;
        req_valid = '1;
        rsp_ready = 1'($urandom_range(0, 1));
        chk("issue_rnd_in", 32'(rnd_in), 32'(edata));
        chk("issue_rnd_rm", 32'(rnd_rm), 32'(rm_eff));
        chk("issue_ready0", 32'(req_ready), 32'd0);
        chk("issue_rsp_valid0", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("wait_rnd_rm", 32'(rnd_rm), 32'(rm_eff));
        chk("wait_rsp_valid0", 32'(rsp_valid), 32'd0);
        // rsp_valid is high when edge T+3 samples it.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("resp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_data", 32'(rsp_data), 32'(exp_rsp));
        chk("resp_id", 32'(rsp_id), 32'(w));
        chk("resp_inv", 32'(rsp_inv_rm), 32'(inv));
        got_id = rsp_id; got_data = rsp_data; got_inv = rsp_inv_rm;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'(exp_rsp));
            chk("hold_id", 32'(rsp_id), 32'(w));
            chk("hold_ready0", 32'(req_ready), 32'd0);
            chk("hold_cnt", 32'(op_cnt), 32'(m_cnt));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        m_cnt = (m_cnt + 1) % (1 << CNTW);
        #1;
        rsp_ready = 1'b0;
        req_valid = '0;
        chk("done_cnt", 32'(op_cnt), 32'(m_cnt));
        chk("done_valid0", 32'(rsp_valid), 32'd0);
        chk("done_busy0", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  v;
        logic [19:0] d;
        logic [2:0]  rm;
        int          hold;
        logic [2:0]  exp_id;
        logic [2:0]  exp_id_fp;
        logic        exp_inv;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [2:0]  gid;
        logic [15:0] gdata;
        logic        ginv;
        int          iters;

        tbl[0] = '{3'b001, 20'h1E018, 3'b000, 0, 3'd0, 3'd0, 1'b0, 16'h1E02};
        tbl[1] = '{3'b111, 20'h12340, 3'b001, 0, 3'd1, 3'd0, 1'b0, 16'h3234};
        tbl[2] = '{3'b111, 20'h0ABCF, 3'b010, 5, 3'd2, 3'd0, 1'b0, 16'h4ABD};
        tbl[3] = '{3'b111, 20'hFFFF1, 3'b011, 0, 3'd0, 3'd0, 1'b0, 16'h6000};
        tbl[4] = '{3'b010, 20'h55550, 3'b101, 0, 3'd1, 3'd1, 1'b1, 16'h5555};
        tbl[5] = '{3'b101, 20'h00010, 3'b111, 1, 3'd2, 3'd0, 1'b1, 16'h0001};
        tbl[6] = '{3'b011, 20'h80008, 3'b000, 0, 3'd0, 3'd0, 1'b0, 16'h8001};

        rst_n = 1'b0; req_valid = '1; req_data = '0; req_rm = '0; rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rnd_in", 32'(rnd_in), 32'd0);
        chk("rst_rnd_rm", 32'(rnd_rm), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_inv", 32'(rsp_inv_rm), 32'd0);
        chk("rst_op_cnt", 32'(op_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_op(tbl[i].v, {NREQ{tbl[i].d}}, {NREQ{tbl[i].rm}}, tbl[i].hold, gid, gdata, ginv);
`ifdef DLF_RND_ARB_FIXED_PRIO_EN
            chk("tbl_id", 32'(gid), 32'(tbl[i].exp_id_fp));
`else
            chk("tbl_id", 32'(gid), 32'(tbl[i].exp_id));
`endif
            chk("tbl_data", 32'(gdata), 32'(tbl[i].exp_data));
            chk("tbl_inv", 32'(ginv), 32'(tbl[i].exp_inv));
        end

        // Reset while the op sits in WAIT: no response, pointer back to requester 0.
        @(negedge clk);
        req_valid = 3'b110; req_data = {3{20'h0F0F3}}; req_rm = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_last = NREQ - 1; m_cnt = 0;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cnt", 32'(op_cnt), 32'd0);
        chk("midrst_rnd_in", 32'(rnd_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_op(3'b111, {20'h11111, 20'h22222, 20'h33338}, 9'b000_000_000, 0, gid, gdata, ginv);
        chk("midrst_first_grant", 32'(gid), 32'd0);
        chk("midrst_first_data", 32'(gdata), 32'h3334);

        // Random traffic until the counter sits at all-ones, then one more to wrap.
        iters = 0;
        while (m_cnt != (1 << CNTW) - 1 && iters < 2000) begin
            run_op(3'($urandom_range(0, 7)), {$urandom, $urandom}, 9'($urandom),
                   $urandom_range(0, 2), gid, gdata, ginv);
            iters++;
        end
        chk("wrap_reached_max", 32'(op_cnt), 32'((1 << CNTW) - 1));
        run_op(3'b100, {NREQ{20'hABCDE}}, {NREQ{3'b010}}, 0, gid, gdata, ginv);
        chk("wrap_to_zero", 32'(op_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
